// File: rtl/csr_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : csr_access_unit
//  Brief    : Execute-stage Zicsr sequencer. Performs a read-modify-write on
//             the CSR register file over its one-cycle-request / busy
//             handshake and returns the old CSR value for rd writeback.
//             Optional build macro CSR_ACCESS_RO_CHECK_EN: blocks writes to
//             the read-only CSR address space (addr[11:10] == 2'b11).
//  Revision : 1.0 - initial release
// ============================================================================
module csr_access_unit #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [2:0]        funct3_i,
    input  logic [CSR_AW-1:0] csr_addr_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [4:0]        rs1_idx_i,
    input  logic [4:0]        rd_idx_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              illegal_o,
    output logic              rd_we_o,
    output logic [XLEN-1:0]   rd_data_o,
    output logic              csr_en_o,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic [XLEN-1:0]   csr_data_o,
    input  logic [XLEN-1:0]   csr_data_i,
    input  logic              csr_busy_i,
    input  logic              csr_exists_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_DONE    = 3'd5,
        S_ILL     = 3'd6
    } state_t;

    localparam logic [1:0] c_OP_W = 2'b01;
    localparam logic [1:0] c_OP_S = 2'b10;

    state_t             r_state;
    state_t             w_next_state;

    logic [2:0]         r_funct3;
    logic [CSR_AW-1:0]  r_addr;
    logic [XLEN-1:0]    r_rs1_data;
    logic [4:0]         r_rs1_idx;
    logic [4:0]         r_rd_idx;
    logic [XLEN-1:0]    r_old;
    logic               r_read_done;
    logic               r_seen_busy;

    logic [XLEN-1:0]    w_src;
    logic [XLEN-1:0]    w_new;
    logic               w_wr_needed;
    logic               w_ro_block;
    logic               w_wait_over;

    // CSRRW/CSRRWI with rd=x0 must not read (no read side effects)
    function automatic logic f_rd_needed(input logic [2:0] f3, input logic [4:0] rd);
        return !((f3[1:0] == c_OP_W) && (rd == 5'd0));
    endfunction

    // Set/clear forms with a zero source (rs1=x0 or uimm=0) must not write
    function automatic logic f_wr_needed(input logic [2:0] f3, input logic [4:0] rs1);
        return !((f3[1:0] != c_OP_W) && (rs1 == 5'd0));
    endfunction

    assign csr_addr_o  = r_addr;
    assign w_wr_needed = f_wr_needed(r_funct3, r_rs1_idx);
    assign w_src       = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_data;
    assign w_wait_over = r_seen_busy && !csr_busy_i;

`ifdef CSR_ACCESS_RO_CHECK_EN
    assign w_ro_block = (r_addr[CSR_AW-1 -: 2] == 2'b11);
`else
    assign w_ro_block = 1'b0;
`endif

    // New CSR value from the old value and the source operand
    always_comb begin
        w_new = w_src;
        case (r_funct3[1:0])
            c_OP_W:  w_new = w_src;
            c_OP_S:  w_new = r_old | w_src;
            default: w_new = r_old & ~w_src;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand latch, busy tracking and old-value capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_funct3    <= '0;
            r_addr      <= '0;
            r_rs1_data  <= '0;
            r_rs1_idx   <= '0;
            r_rd_idx    <= '0;
            r_old       <= '0;
            r_read_done <= 1'b0;
            r_seen_busy <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_funct3    <= funct3_i;
                        r_addr      <= csr_addr_i;
                        r_rs1_data  <= rs1_data_i;
                        r_rs1_idx   <= rs1_idx_i;
                        r_rd_idx    <= rd_idx_i;
                        r_old       <= '0;
                        r_read_done <= 1'b0;
                        r_seen_busy <= 1'b0;
                    end
                end
                S_RD_WAIT, S_WR_WAIT: begin
                    if (csr_busy_i) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_seen_busy <= 1'b0;
                        if (r_state == S_RD_WAIT) begin
                            r_old       <= csr_data_i;
                            r_read_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next_state = r_state;
        busy_o       = (r_state != S_IDLE);
        done_o       = 1'b0;
        illegal_o    = 1'b0;
        rd_we_o      = 1'b0;
        rd_data_o    = '0;
        csr_en_o     = 1'b0;
        csr_we_o     = 1'b0;
        csr_data_o   = '0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (funct3_i[1:0] == 2'b00) begin
                        w_next_state = S_ILL;
                    end else if (f_rd_needed(funct3_i, rd_idx_i)) begin
                        w_next_state = S_RD_REQ;
                    end else begin
                        w_next_state = S_WR_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (csr_exists_i) begin
                    csr_en_o     = 1'b1;
                    w_next_state = S_RD_WAIT;
                end else begin
                    w_next_state = S_ILL;
                end
            end
            S_RD_WAIT: begin
                if (w_wait_over) begin
                    w_next_state = w_wr_needed ? S_WR_REQ : S_DONE;
                end
            end
            S_WR_REQ: begin
                if (csr_exists_i && !w_ro_block) begin
                    csr_en_o     = 1'b1;
                    csr_we_o     = 1'b1;
                    csr_data_o   = w_new;
                    w_next_state = S_WR_WAIT;
                end else begin
                    w_next_state = S_ILL;
                end
            end
            S_WR_WAIT: begin
                if (w_wait_over) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done_o       = 1'b1;
                rd_data_o    = r_old;
                rd_we_o      = r_read_done && (r_rd_idx != 5'd0);
                w_next_state = S_IDLE;
            end
            S_ILL: begin
                illegal_o    = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
